// File: rtl/picorv_pcpi_muldiv_if.sv
// picorv_pcpi_muldiv_if: PCPI bus between the core (master) and a coprocessor (slave).
interface picorv_pcpi_muldiv_if #(parameter int XLEN = 32);
  logic            pcpi_valid;
  logic [31:0]     pcpi_insn;
  logic [XLEN-1:0] pcpi_rs1_data;
  logic [XLEN-1:0] pcpi_rs2_data;
  logic            pcpi_ready;
  logic            pcpi_wb_write;
  logic [XLEN-1:0] pcpi_wb_data;
  logic            pcpi_br_enable;
  logic [XLEN-1:0] pcpi_br_nextpc;
  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1_data, pcpi_rs2_data,
    input  pcpi_ready, pcpi_wb_write, pcpi_wb_data, pcpi_br_enable, pcpi_br_nextpc
  );
  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1_data, pcpi_rs2_data,
    output pcpi_ready, pcpi_wb_write, pcpi_wb_data, pcpi_br_enable, pcpi_br_nextpc
  );
endinterface

// File: rtl/picorv_pcpi_muldiv.sv
// picorv_pcpi_muldiv: RV32M PCPI coprocessor with iterative shift-add multiplier and restoring divider.
// Define PICORV_PCPI_MULDIV_EARLYOUT_EN to finish divide-by-zero and signed-overflow DIV/REM in one cycle.
module picorv_pcpi_muldiv #(
  parameter int XLEN       = 32,
  parameter int ENABLE_MUL = 1,
  parameter int ENABLE_DIV = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  picorv_pcpi_muldiv_if.slave    bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [2*XLEN-1:0] acc_q, acc_d;

  logic [2:0]        f3;
  logic [XLEN-1:0]   rs1, rs2, mag1, mag2;
  logic              is_div, claim, sgn1, sgn2, s1, s2, b_zero, early;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] step, prod;
  logic [XLEN-1:0]   qv, rv, result;

  assign f3  = bus.pcpi_insn[14:12];
  assign rs1 = bus.pcpi_rs1_data;
  assign rs2 = bus.pcpi_rs2_data;

  always_comb begin
    is_div = f3[2];
    claim  = bus.pcpi_valid && bus.pcpi_insn[6:0] == 7'b0110011 && bus.pcpi_insn[31:25] == 7'b0000001 &&
             (is_div ? ENABLE_DIV != 0 : ENABLE_MUL != 0);
    sgn1   = f3 inside {3'd1, 3'd2, 3'd4, 3'd6};
    sgn2   = f3 inside {3'd1, 3'd4, 3'd6};
    s1     = sgn1 && rs1[XLEN-1];
    s2     = sgn2 && rs2[XLEN-1];
    mag1   = s1 ? -rs1 : rs1;
    mag2   = s2 ? -rs2 : rs2;
    b_zero = rs2 == {XLEN{1'b0}};
`ifdef PICORV_PCPI_MULDIV_EARLYOUT_EN
    early  = is_div && (b_zero || (sgn2 && rs1 == {1'b1, {(XLEN-1){1'b0}}} && &rs2));
`else
    early  = 1'b0;
`endif
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_sh - {1'b0, a_q};
    step     = !op_q[2]      ? {mul_sum, acc_q[XLEN-1:1]} :
               div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0} :
                                {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    a_d     = a_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: if (claim) begin
        state_d = early ? DONE : BUSY;
        cnt_d   = CW'(XLEN-1);
        op_d    = f3;
        neg_d   = is_div ? (f3[1] ? s1 : (s1 ^ s2) && !b_zero) : s1 ^ s2;
        a_d     = is_div ? mag2 : mag1;
        acc_d   = early ? {(b_zero ? mag1 : {XLEN{1'b0}}), (b_zero ? {XLEN{1'b1}} : mag1)}
                        : {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
      end
      BUSY: if (!bus.pcpi_valid) state_d = IDLE;
      else begin
        acc_d   = step;
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? DONE : BUSY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      a_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    prod   = neg_q ? -acc_q : acc_q;
    qv     = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rv     = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    result = op_q[2] ? (op_q[1] ? rv : qv) : (op_q == 3'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end

  assign bus.pcpi_ready     = state_q == DONE;
  assign bus.pcpi_wb_write  = state_q == DONE;
  assign bus.pcpi_wb_data   = state_q == DONE ? result : {XLEN{1'b0}};
  assign bus.pcpi_br_enable = 1'b0;
  assign bus.pcpi_br_nextpc = {XLEN{1'b0}};
endmodule
